// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e : responder FSM states
//   op_e    : latched access kind
//   ERR_WORD: read data returned for out-of-range reads
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WS_W   = 4;

  localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 32, read data registered.
//   clk_i   : clock
//   we_i    : write enable (write at rising edge)
//   addr_i  : word index, shared by read and write
//   wdata_i : write data
//   rdata_o : word at addr_i sampled at the last rising edge (old data on write)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage has no reset; contents survive RST.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the pipeline data-port handshake, backed by an internal RAM
// with a fixed, programmable number of wait states per access.
//   CLK, RST          : clock, synchronous active-high reset
//   RRam / WRam       : read / write request levels (write wins if both)
//   daddr, ddata_w    : byte address (bits [1:0] ignored), write data
//   ddata_r           : read data, held from one read completion to the next
//   done_ext          : one-cycle completion pulse
//   err               : sticky out-of-range flag, cleared only by RST
//   rd_count/wr_count : completed read / write accesses, wrapping
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RRam,
  input  logic              WRam,
  input  logic [31:0]       daddr,
  input  logic [DATA_W-1:0] ddata_w,
  output logic [DATA_W-1:0] ddata_r,
  output logic              done_ext,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q;
  op_e               op_q;
  logic [AW-1:0]     idx_q;
  logic              oor_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WS_W-1:0]   cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              rd_sel_q;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;

  logic              req_c;
  op_e               op_in_c;
  logic [AW-1:0]     idx_in_c;
  logic              oor_in_c;
  logic              accept_c;
  logic              enter_done_c;
  op_e               op_c;
  logic [AW-1:0]     idx_c;
  logic              oor_c;
  logic [DATA_W-1:0] wdata_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr_c;

  assign unused_addr_c = ^daddr[1:0];

  // Request decode in IDLE.
  assign req_c    = RRam | WRam;
  assign op_in_c  = WRam ? OP_WR : OP_RD;
  assign idx_in_c = daddr[AW+1:2];
  assign oor_in_c = (daddr[31:2] >= 30'(DEPTH));
  assign accept_c = (state_q == IDLE) && req_c;

  // The edge entering DONE is where a write commits and read data lands.
  assign enter_done_c = (accept_c && (WAIT_STATES == 0)) ||
                        ((state_q == WAIT) && (cnt_q == '0));

  // With zero wait states DONE is entered straight from IDLE, so the RAM
  // must see the live request; otherwise it sees the latched copy.
  always_comb begin
    op_c    = op_q;
    idx_c   = idx_q;
    oor_c   = oor_q;
    wdata_c = wdata_q;
    if (state_q == IDLE) begin
      op_c    = op_in_c;
      idx_c   = idx_in_c;
      oor_c   = oor_in_c;
      wdata_c = ddata_w;
    end
  end

  assign ram_we_c = enter_done_c && (op_c == OP_WR) && !oor_c && !RST;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (ram_we_c),
    .addr_i  (idx_c),
    .wdata_i (wdata_c),
    .rdata_o (ram_rdata)
  );

  // FSM, request latches, counters and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      rd_sel_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      done_q   <= enter_done_c;
      rd_sel_q <= enter_done_c && (op_c == OP_RD) && !oor_c;

      if (enter_done_c) begin
        if (oor_c) begin
          err_q <= 1'b1;
        end
        if (op_c == OP_RD) begin
          rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          if (oor_c) begin
            hold_q <= ERR_WORD;
          end
        end else begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
      end

      // Freeze the RAM word as DONE ends so ddata_r holds until the next read.
      if (rd_sel_q) begin
        hold_q <= ram_rdata;
      end

      unique case (state_q)
        IDLE: begin
          if (req_c) begin
            op_q    <= op_in_c;
            idx_q   <= idx_in_c;
            oor_q   <= oor_in_c;
            wdata_q <= ddata_w;
            cnt_q   <= WS_W'(WAIT_STATES - 1);
            state_q <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - WS_W'(1);
          end
        end
        DONE:    state_q <= HOLDOFF;
        HOLDOFF: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // During DONE of an in-range read the RAM output register drives ddata_r
  // directly; at all other times the held copy does.
  assign ddata_r  = rd_sel_q ? ram_rdata : hold_q;
  assign done_ext = done_q;
  assign err      = err_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses two wait states,
// instance 1 uses zero wait states; both share clock and reset.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        rram [2];
  logic        wram [2];
  logic [31:0] daddr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        done [2];
  logic        err [2];
  logic [15:0] rdc [2];
  logic [15:0] wrc [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(2), .CNT_W(16)) u_ws2 (
    .CLK(CLK), .RST(RST), .RRam(rram[0]), .WRam(wram[0]), .daddr(daddr[0]),
    .ddata_w(wdat[0]), .ddata_r(rdat[0]), .done_ext(done[0]), .err(err[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0])
  );

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0), .CNT_W(16)) u_ws0 (
    .CLK(CLK), .RST(RST), .RRam(rram[1]), .WRam(wram[1]), .daddr(daddr[1]),
    .ddata_w(wdat[1]), .ddata_r(rdat[1]), .done_ext(done[1]), .err(err[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake: request in cycle k, optional addr/data change in k+1,
  // wait (bounded) for done, drop request the cycle after done, then
  // confirm done_ext was a single pulse. Returns at the HOLDOFF negedge.
  task automatic access(input int u, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] addr2, input logic [31:0] data2,
                        input int exp_lat, input string tag,
                        output logic [31:0] rd_val);
    int lat;
    lat = -1;
    @(posedge CLK); #1;
    rram[u]  = rd;
    wram[u]  = wr;
    daddr[u] = addr;
    wdat[u]  = data;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
        if (i == 1) begin
          daddr[u] = addr2;
          wdat[u]  = data2;
        end
      end
      @(negedge CLK);
      if (done[u]) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    rd_val = rdat[u];
    @(posedge CLK); #1;
    rram[u] = 1'b0;
    wram[u] = 1'b0;
    @(negedge CLK);
    check({tag, " single pulse"}, 32'(done[u]), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int pulses;
    RST = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rram[u] = 1'b0; wram[u] = 1'b0; daddr[u] = '0; wdat[u] = '0;
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst done", 32'(done[0]), 32'd0);
    check("rst ddata_r", rdat[0], 32'd0);
    check("rst err", 32'(err[0]), 32'd0);
    check("rst rd_count", 32'(rdc[0]), 32'd0);
    check("rst wr_count", 32'(wrc[0]), 32'd0);
    check("rst ddata_r ws0", rdat[1], 32'd0);

    // Write then read back, two wait states: latency 3 cycles.
    access(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 32'h10, 32'hCAFEF00D, 3, "wr10", v);
    check("wr10 wr_count", 32'(wrc[0]), 32'd1);
    check("wr10 rd_count", 32'(rdc[0]), 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, 3, "rd10", v);
    check("rd10 data", v, 32'hCAFEF00D);
    check("rd10 held", rdat[0], 32'hCAFEF00D);
    check("rd10 rd_count", 32'(rdc[0]), 32'd1);

    // Simultaneous read+write: write wins, ddata_r untouched.
    access(0, 1'b1, 1'b1, 32'h20, 32'h1234, 32'h20, 32'h1234, 3, "rdwr20", v);
    check("rdwr20 ddata_r kept", v, 32'hCAFEF00D);
    check("rdwr20 wr_count", 32'(wrc[0]), 32'd2);
    check("rdwr20 rd_count", 32'(rdc[0]), 32'd1);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 32'h0, 3, "rd20", v);
    check("rd20 data", v, 32'h1234);

    // Out of range: 0x1000 would alias word 0 if not dropped.
    access(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 32'h0, 32'h11111111, 3, "wr0", v);
    check("pre-oor err", 32'(err[0]), 32'd0);
    access(0, 1'b0, 1'b1, 32'h1000, 32'h00000BAD, 32'h1000, 32'h00000BAD, 3, "wroor", v);
    check("wroor err", 32'(err[0]), 32'd1);
    check("wroor wr_count", 32'(wrc[0]), 32'd4);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3, "rd0", v);
    check("rd0 no alias", v, 32'h11111111);
    access(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000, 32'h0, 3, "rdoor", v);
    check("rdoor data", v, 32'hDEADBEEF);
    check("rdoor held", rdat[0], 32'hDEADBEEF);
    check("rdoor rd_count", 32'(rdc[0]), 32'd4);
    check("rdoor err sticky", 32'(err[0]), 32'd1);

    // Address/data change after acceptance is ignored.
    access(0, 1'b0, 1'b1, 32'h40, 32'h5A5A, 32'h40, 32'h5A5A, 3, "wr40", v);
    access(0, 1'b0, 1'b1, 32'h44, 32'h77, 32'h40, 32'h99, 3, "wr44chg", v);
    access(0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h44, 32'h0, 3, "rd44", v);
    check("rd44 data", v, 32'h77);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 32'h0, 3, "rd40", v);
    check("rd40 unchanged", v, 32'h5A5A);

    // Zero wait states: latency 1; a read held through HOLDOFF is
    // ignored there and re-accepted in IDLE, done again 3 cycles later.
    access(1, 1'b0, 1'b1, 32'h4, 32'h77AA, 32'h4, 32'h77AA, 1, "ws0 wr4", v);
    check("ws0 wr_count", 32'(wrc[1]), 32'd1);
    @(posedge CLK); #1;
    rram[1] = 1'b1; daddr[1] = 32'h4;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
        if (i == 5) rram[1] = 1'b0;
      end
      @(negedge CLK);
      check($sformatf("ws0 held done@%0d", i), 32'(done[1]), (i == 1 || i == 4) ? 32'd1 : 32'd0);
      if (i == 4) check("ws0 held data", rdat[1], 32'h77AA);
    end
    check("ws0 rd_count", 32'(rdc[1]), 32'd2);

    // Reset mid-WAIT aborts a pending write; array contents survive.
    access(0, 1'b0, 1'b1, 32'h8, 32'hAA, 32'h8, 32'hAA, 3, "wr8", v);
    @(posedge CLK); #1;
    wram[0] = 1'b1; daddr[0] = 32'h8; wdat[0] = 32'h55;
    @(posedge CLK); #1;
    RST = 1'b1; wram[0] = 1'b0;
    pulses = 0;
    @(negedge CLK);
    if (done[0]) pulses++;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (done[0]) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort wr_count", 32'(wrc[0]), 32'd0);
    check("abort rd_count", 32'(rdc[0]), 32'd0);
    check("abort err", 32'(err[0]), 32'd0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h8, 32'h0, 3, "rd8", v);
    check("rd8 not committed", v, 32'hAA);
    check("rd8 rd_count", 32'(rdc[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
